chunked_addsub: RTL and testbench
=================================

CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 1, giving the bits processed per clock; WIDTH mod CHUNK SHALL be 0; N = WIDTH/CHUNK.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  request a new operation; sampled on rising clk.
REQ-006 Port a  input  WIDTH  operand A, captured when start is accepted.
REQ-007 Port b  input  WIDTH  operand B, captured when start is accepted.
REQ-008 Port sub  input  1  mode (0 = add, 1 = subtract), captured when start is accepted.
REQ-009 Port cin  input  1  carry-in (add) or borrow-in (sub), captured when start is accepted.
REQ-010 Port busy  output  1  operation in progress.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port sum  output  WIDTH  result.
REQ-013 Port carry  output  1  carry out of the MSB (for sub, 1 = no borrow).
REQ-014 Port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 States SHALL be IDLE, RUN and DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; on acceptance, a, b, sub and cin are latched, the chunk counter is cleared, and the state goes to RUN.
REQ-017 start in RUN SHALL be ignored, with no effect on the latched operands or the counter.
REQ-018 Effective operand B SHALL be b when sub = 0 and ~b when sub = 1; effective carry-in SHALL be cin XOR sub (sub, cin = 0 gives a - b; cin = 1 gives a - b - 1).
REQ-019 Each RUN edge SHALL add one CHUNK-bit slice, LSB slice first, using the carry registered from the previous slice; the counter increments by 1.
REQ-020 On the N-th RUN edge the state SHALL go to DONE, and sum, carry and overflow SHALL be updated together on that edge.
REQ-021 Latency: with start accepted at edge E0, done SHALL be high exactly in the cycle after edge E0+N and low otherwise; busy SHALL be high exactly while the state is RUN.
REQ-022 DONE SHALL last one cycle, then go to IDLE, unless start is accepted in DONE, in which case it goes directly to RUN (back-to-back operation, no idle cycle).
REQ-023 sum, carry and overflow SHALL hold their values from completion until the next completion; intermediate slice results SHALL never appear on the outputs.
REQ-024 overflow SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-025 Results SHALL be modulo 2^WIDTH; the carry out of the final slice SHALL drive carry.
REQ-026 For CHUNK = WIDTH (N = 1), the operation SHALL complete in a single RUN cycle under the same rules.

Reset
REQ-027 rst SHALL force, asynchronously, state = IDLE, counter = 0, internal carry = 0, busy = 0, done = 0, sum = 0, carry = 0, overflow = 0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse; after release, the block SHALL require a new start.

Structure
REQ-029 State encodings (IDLE = 0, RUN = 1, DONE = 2) SHALL be defined in the shared package addsub_pkg.
REQ-030 Slice arithmetic SHALL be a combinational sub-module chunk_adder (parameter CHUNK; inputs a, b, cin; outputs sum, carry, and carry into the top bit) built as a ripple of full adders.
REQ-031 The counter width SHALL be clog2(N), with a minimum of 1.

Verification
REQ-032 WIDTH = 8, CHUNK = 1: a = 200, b = 100, sub = 0, cin = 0 -> done 8 cycles after start, sum = 0x2C, carry = 1, overflow = 0.
REQ-033 WIDTH = 8, CHUNK = 4: a = 5, b = 7, sub = 1, cin = 0 -> done 2 cycles after start, sum = 0xFE, carry = 0, overflow = 0.
REQ-034 WIDTH = 8, CHUNK = 2: a = 0x7F, b = 0x01, add -> sum = 0x80, carry = 0, overflow = 1.
REQ-035 WIDTH = 8, CHUNK = 1: start pulsed again 3 cycles into RUN with different operands -> ignored; original result delivered on schedule.
REQ-036 WIDTH = 8, CHUNK = 1: rst asserted mid-RUN -> all outputs 0 immediately, no done pulse; a later start then operates normally.
REQ-037 WIDTH = 8, CHUNK = 4: start held in the DONE cycle with a = 1, b = 1 -> busy high the next cycle, done after 2 more cycles, sum = 0x02.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked (bit-serial / digit-serial) adder-subtractor.
// Holds the controller state encoding and the counter sizing helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-slice operation still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder for one slice.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             carry,
  output logic             carry_msb
);

  logic c_r;

  always_comb begin
    sum       = '0;
    carry_msb = cin;
    c_r       = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) carry_msb = c_r;
      sum[i] = a[i] ^ b[i] ^ c_r;
      c_r    = (a[i] & b[i]) | (c_r & (a[i] ^ b[i]));
    end
    carry = c_r;
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock, LSB slice first,
// and publishes sum/carry/overflow only when the last slice completes.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] sl_sum;
  logic             sl_c, sl_cmsb;
  logic [WIDTH-1:0] acc_next;

  // Operand registers shift right so the active slice is always at bit 0.
  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a         (a_q[CHUNK-1:0]),
    .b         (b_q[CHUNK-1:0]),
    .cin       (c_q),
    .sum       (sl_sum),
    .carry     (sl_c),
    .carry_msb (sl_cmsb)
  );

  // Partial result fills from the top; after N slices it is aligned.
  assign acc_next = (acc_q >> CHUNK) | (WIDTH'(sl_sum) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        acc_d = acc_next;
        c_d   = sl_c;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          c_d     = 1'b0;
          sum_d   = acc_next;
          carry_d = sl_c;
          ovf_d   = sl_cmsb ^ sl_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = cin ^ sub;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Working data is always overwritten on acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: four instances (CHUNK = 1, 2, 4, 8) share stimulus and are
// compared every cycle against an arithmetic model, plus literal result/latency checks.
module tb_chunked_addsub;

  localparam int W  = 8;
  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;

  logic       busy_o  [NI];
  logic       done_o  [NI];
  logic       carry_o [NI];
  logic       ovf_o   [NI];
  logic [7:0] sum_o   [NI];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chunked_addsub #(.WIDTH(W), .CHUNK(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .cin      (cin),
      .busy     (busy_o[g]),
      .done     (done_o[g]),
      .sum      (sum_o[g]),
      .carry    (carry_o[g]),
      .overflow (ovf_o[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer add of A, effective B and effective carry-in.
  function automatic logic [8:0] add_full(input logic [7:0] x, input logic [7:0] y,
                                          input logic s, input logic ci);
    logic [7:0] ey;
    ey = s ? ~y : y;
    return {1'b0, x} + {1'b0, ey} + 9'(ci ^ s);
  endfunction

  function automatic logic ovf_of(input logic [7:0] x, input logic [7:0] y,
                                  input logic s, input logic ci);
    logic [7:0] ey;
    logic [8:0] f;
    ey = s ? ~y : y;
    f  = add_full(x, y, s, ci);
    return (x[7] == ey[7]) && (f[7] != x[7]);
  endfunction

  // Model: each instance is either idle or counting down the N cycles of an accepted op.
  int         rem    [NI] = '{default: 0};
  bit         done_m [NI] = '{default: 1'b0};
  logic [7:0] sum_m  [NI] = '{default: 8'd0};
  logic [7:0] psum   [NI] = '{default: 8'd0};
  bit         c_m    [NI] = '{default: 1'b0};
  bit         v_m    [NI] = '{default: 1'b0};
  bit         pc     [NI] = '{default: 1'b0};
  bit         pv     [NI] = '{default: 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        rem[k]    <= 0;
        done_m[k] <= 1'b0;
        sum_m[k]  <= 8'd0;
        c_m[k]    <= 1'b0;
        v_m[k]    <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        done_m[k] <= 1'b0;
        if (rem[k] > 0) begin
          rem[k] <= rem[k] - 1;
          if (rem[k] == 1) begin
            done_m[k] <= 1'b1;
            sum_m[k]  <= psum[k];
            c_m[k]    <= pc[k];
            v_m[k]    <= pv[k];
          end
        end else if (start) begin
          rem[k]          <= 8 >> k;
          {pc[k], psum[k]} <= add_full(a, b, sub, cin);
          pv[k]           <= ovf_of(a, b, sub, cin);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("i%0d busy", k), 32'(busy_o[k]), 32'(rem[k] > 0));
        check($sformatf("i%0d done", k), 32'(done_o[k]), 32'(done_m[k]));
        check($sformatf("i%0d sum", k), 32'(sum_o[k]), 32'(sum_m[k]));
        check($sformatf("i%0d carry", k), 32'(carry_o[k]), 32'(c_m[k]));
        check($sformatf("i%0d ovf", k), 32'(ovf_o[k]), 32'(v_m[k]));
      end
    end
  end

  task automatic launch(input logic [7:0] xa, input logic [7:0] xb, input logic xs, input logic xc);
    @(posedge clk); #1;
    a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic measure(input int k, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_o[k]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic idle_gap();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int dcount;

    #2 rst = 1'b1;
    #1;
    check("reset busy", 32'(busy_o[0]), 32'd0);
    check("reset done", 32'(done_o[0]), 32'd0);
    check("reset sum", 32'(sum_o[0]), 32'd0);
    check("reset carry", 32'(carry_o[0]), 32'd0);
    check("reset ovf", 32'(ovf_o[0]), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 200 + 100 with single-bit slices
    launch(8'd200, 8'd100, 1'b0, 1'b0);
    measure(0, lat);
    check("add200 latency", 32'(lat), 32'd8);
    check("add200 sum", 32'(sum_o[0]), 32'h2C);
    check("add200 carry", 32'(carry_o[0]), 32'd1);
    check("add200 ovf", 32'(ovf_o[0]), 32'd0);

    // 5 - 7 with 4-bit slices
    idle_gap();
    launch(8'd5, 8'd7, 1'b1, 1'b0);
    measure(2, lat);
    check("sub5_7 latency", 32'(lat), 32'd2);
    check("sub5_7 sum", 32'(sum_o[2]), 32'hFE);
    check("sub5_7 carry", 32'(carry_o[2]), 32'd0);
    check("sub5_7 ovf", 32'(ovf_o[2]), 32'd0);

    // 0x7F + 1 with 2-bit slices: signed overflow
    idle_gap();
    launch(8'h7F, 8'h01, 1'b0, 1'b0);
    measure(1, lat);
    check("ovf latency", 32'(lat), 32'd4);
    check("ovf sum", 32'(sum_o[1]), 32'h80);
    check("ovf carry", 32'(carry_o[1]), 32'd0);
    check("ovf flag", 32'(ovf_o[1]), 32'd1);

    // Whole-word slice: 0x80 + 0x80 + 1
    idle_gap();
    launch(8'h80, 8'h80, 1'b0, 1'b1);
    measure(3, lat);
    check("n1 latency", 32'(lat), 32'd1);
    check("n1 sum", 32'(sum_o[3]), 32'h01);
    check("n1 carry", 32'(carry_o[3]), 32'd1);
    check("n1 ovf", 32'(ovf_o[3]), 32'd1);

    // start pulsed during RUN must not disturb the op in flight
    idle_gap();
    launch(8'd10, 8'd20, 1'b0, 1'b0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        start = 1'b1; a = 8'd1; b = 8'd1;
      end else if (c == 3) begin
        start = 1'b0;
      end
      if (done_o[0]) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check("ignore latency", 32'(lat), 32'd8);
    check("ignore sum", 32'(sum_o[0]), 32'd30);

    // Asynchronous reset mid-RUN
    idle_gap();
    launch(8'd50, 8'd60, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy_o[0]), 32'd0);
    check("abort done", 32'(done_o[0]), 32'd0);
    check("abort sum", 32'(sum_o[0]), 32'd0);
    check("abort carry", 32'(carry_o[0]), 32'd0);
    check("abort ovf", 32'(ovf_o[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_o[0]) dcount++;
    end
    check("abort no done", 32'(dcount), 32'd0);
    launch(8'd3, 8'd4, 1'b0, 1'b0);
    measure(0, lat);
    check("after abort latency", 32'(lat), 32'd8);
    check("after abort sum", 32'(sum_o[0]), 32'd7);

    // Back-to-back: start held in the DONE cycle of the 4-bit-slice instance
    idle_gap();
    launch(8'd5, 8'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b first done", 32'(done_o[2]), 32'd1);
    a = 8'd1; b = 8'd1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", 32'(busy_o[2]), 32'd1);
    check("b2b no done", 32'(done_o[2]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b second done", 32'(done_o[2]), 32'd1);
    check("b2b sum", 32'(sum_o[2]), 32'h02);

    // Randomized traffic with occasional asynchronous resets
    idle_gap();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      rst   = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
